ir_decode_queue: RTL
====================

Name: ir_decode_queue

Overview:
- Clocked, parametrised successor to the combinational instruction-register decode.
- Buffers fetched {pc, inst} pairs in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Presents a fully decoded view of the head entry to the execute stage: class, register fields, extended immediate, jump target and illegal-opcode flag.
- Sits between the fetch unit and the register-file/execute stage; supports a pipeline flush.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- IMM_SIGNED, 1, 1 = sign-extend imm16 to 32 bits, 0 = zero-extend.
- PC_W, 32, PC width; fixed 32 for the current ISA, checked at elaboration.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all queued entries.
- in_valid  in  1  fetch presents pc/inst.
- in_ready  out  1  queue can accept.
- in_pc  in  32  PC of the instruction.
- in_inst  in  32  raw instruction word.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes the head this cycle.
- out_pc  out  32  PC of the head entry.
- opcode  out  6  inst[31:26].
- cls  out  2  0 = R, 1 = I, 2 = J, 3 = S.
- illegal  out  1  opcode matches no class.
- rd  out  4  inst[25:22] (R, I, S).
- rs1  out  4  inst[21:18] (R, I).
- rs2  out  4  inst[17:14] (R only).
- imm_ext  out  32  extended inst[17:2] (I only).
- mode  out  2  inst[1:0] (I only).
- jtarget  out  32  {pc[31:26], inst[25:0]} (J only).
- count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (rst_n low, asynchronous): read/write pointers and count = 0.
  - in_ready = 1 and out_valid = 0.
  - All decoded outputs and out_pc = 0.
- Push occurs when in_valid && in_ready at a rising edge.
- Pop occurs when out_valid && out_ready at a rising edge.
- in_ready = (count != DEPTH); out_valid = (count != 0). Both depend on registered state only, with no combinational input-to-output path.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Full: in_ready = 0, so there is no push even if a pop happens in the same cycle.
- Empty: out_valid = 0, so there is no pop.
- Latency: an entry pushed at edge N is visible on the outputs after edge N; out_valid is high in cycle N+1.
- Pointers wrap modulo DEPTH.
- flush has priority over push and pop: at the edge, count and pointers go to 0 and any concurrent push is dropped.
- Decode is combinational from the head entry. Classification by opcode op:
  - R: op[5:2] == 0000 and op != 000011.
  - I: op[5:2] in {0001, 0010}, or op == 000011.
  - J: op in {001100, 001101}.
  - S: op in {001111, 010000}.
  - Otherwise: illegal = 1, cls = 0, and all field outputs = 0.
- Fields not used by the decoded class are driven to 0; no latched stale values.
- When out_valid = 0, all decoded outputs and out_pc = 0.
- Data outputs must be stable while out_valid && !out_ready.
- Reset asserted mid-transfer discards all entries immediately.

Optional Feature:
- Macro: IR_FALLTHROUGH_EN.
- Defined:
  - When count == 0 and in_valid is high, out_valid = 1 and the outputs decode in_pc/in_inst combinationally (zero-cycle latency).
  - If out_ready is also high, the entry is consumed without being written.
  - Otherwise it is written as a normal push.
- Undefined: behaviour exactly as above, with 1-cycle minimum latency.

Test Plan:
- Reset then push pc=0x100, inst=0x00C48000 -> next cycle out_valid=1, cls=0, rd=3, rs1=1, rs2=2, imm_ext=0, illegal=0.
- Push inst=0x115BFFFD -> cls=1, rd=5, rs1=6, mode=1, imm_ext=0xFFFFFFFF (IMM_SIGNED=1) or 0x0000FFFF (IMM_SIGNED=0), rs2=0.
- Push pc=0xA4000010, inst=0x30000123 -> cls=2, jtarget=0xA4000123. Push inst=0x40C00000 -> cls=3, rd=3. Push inst=0xFC000000 -> illegal=1, all fields 0.
- Hold out_ready=0 and push DEPTH entries -> count=DEPTH, in_ready=0. Then push and pop in the same cycle -> only the pop occurs and count=DEPTH-1. Continue with out_ready=1 -> FIFO order preserved across pointer wrap.
- With count=2, assert flush together with a push -> next cycle count=0, out_valid=0, pushed entry lost.
- With IR_FALLTHROUGH_EN, empty queue, in_valid=1 and out_ready=1 in the same cycle -> out_valid=1 that cycle with a correct decode, and count stays 0.

Source files
------------

// File: rtl/ir_decode_queue_if.sv
// Fetch-to-execute handshake bundle for ir_decode_queue: push side, decoded head view, flush.
// The slave modport is the queue; the master modport is the fetch/execute environment.
interface ir_decode_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_pc;
  logic [31:0]   in_inst;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [5:0]    opcode;
  logic [1:0]    cls;
  logic          illegal;
  logic [3:0]    rd;
  logic [3:0]    rs1;
  logic [3:0]    rs2;
  logic [31:0]   imm_ext;
  logic [1:0]    mode;
  logic [31:0]   jtarget;
  logic [CW-1:0] count;

  modport slave (
    input  flush, in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, opcode, cls, illegal, rd, rs1, rs2,
           imm_ext, mode, jtarget, count
  );

  modport master (
    output flush, in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, opcode, cls, illegal, rd, rs1, rs2,
           imm_ext, mode, jtarget, count
  );
endinterface

// File: rtl/ir_decode_queue.sv
// DEPTH-entry {pc, inst} FIFO with a combinational decode of the head entry.
// Optional IR_FALLTHROUGH_EN: an empty queue presents the incoming entry with zero latency.
module ir_decode_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter bit          IMM_SIGNED = 1'b1,
  parameter int unsigned PC_W       = 32
) (
  input logic                clk,
  input logic                rst_n,
  ir_decode_queue_if.slave   bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (PC_W != 32) begin : g_pc_w_chk
    $error("ir_decode_queue: PC_W must be 32");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("ir_decode_queue: DEPTH must be a power of two >= 2");
  end

  logic [31:0]   r_pc_mem   [DEPTH];
  logic [31:0]   r_inst_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          w_q_valid;
  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_head_pc;
  logic [31:0]   w_head_inst;
  logic [5:0]    w_op;
  logic [15:0]   w_imm16;

  assign w_q_valid  = (r_count != '0);
  assign w_in_ready = (r_count != CW'(DEPTH));
  assign w_pop      = w_q_valid && bus.out_ready;

`ifdef IR_FALLTHROUGH_EN
  logic w_ft;
  assign w_ft        = !w_q_valid && bus.in_valid;
  assign w_out_valid = w_q_valid || w_ft;
  // A bypassed entry taken in the same cycle never touches the storage.
  assign w_push      = bus.in_valid && w_in_ready && !(w_ft && bus.out_ready);
  assign w_head_pc   = w_ft ? bus.in_pc   : r_pc_mem[r_rptr];
  assign w_head_inst = w_ft ? bus.in_inst : r_inst_mem[r_rptr];
`else
  assign w_out_valid = w_q_valid;
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_head_pc   = r_pc_mem[r_rptr];
  assign w_head_inst = r_inst_mem[r_rptr];
`endif

  always_ff @(posedge clk) begin
    if (w_push && !bus.flush) begin
      r_pc_mem[r_wptr]   <= bus.in_pc;
      r_inst_mem[r_wptr] <= bus.in_inst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  assign w_op    = w_head_inst[31:26];
  assign w_imm16 = w_head_inst[17:2];

  always_comb begin
    bus.out_pc  = '0;
    bus.opcode  = '0;
    bus.cls     = 2'd0;
    bus.illegal = 1'b0;
    bus.rd      = '0;
    bus.rs1     = '0;
    bus.rs2     = '0;
    bus.imm_ext = '0;
    bus.mode    = '0;
    bus.jtarget = '0;
    if (w_out_valid) begin
      bus.out_pc = w_head_pc;
      bus.opcode = w_op;
      if (w_op[5:2] == 4'b0000 && w_op != 6'b000011) begin
        bus.cls = 2'd0;
        bus.rd  = w_head_inst[25:22];
        bus.rs1 = w_head_inst[21:18];
        bus.rs2 = w_head_inst[17:14];
      end else if (w_op[5:2] == 4'b0001 || w_op[5:2] == 4'b0010 || w_op == 6'b000011) begin
        bus.cls     = 2'd1;
        bus.rd      = w_head_inst[25:22];
        bus.rs1     = w_head_inst[21:18];
        bus.imm_ext = IMM_SIGNED ? {{16{w_imm16[15]}}, w_imm16} : {16'h0000, w_imm16};
        bus.mode    = w_head_inst[1:0];
      end else if (w_op == 6'b001100 || w_op == 6'b001101) begin
        bus.cls     = 2'd2;
        bus.jtarget = {w_head_pc[31:26], w_head_inst[25:0]};
      end else if (w_op == 6'b001111 || w_op == 6'b010000) begin
        bus.cls = 2'd3;
        bus.rd  = w_head_inst[25:22];
      end else begin
        bus.illegal = 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.count     = r_count;
endmodule
